// File: rtl/pipe_out_fifo_if.sv
// Handshake bundle between the fixed-latency pipeline, the output FIFO and its consumer.
// master: environment (pipeline producer + consumer); slave: the FIFO itself.
interface pipe_out_fifo_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/pipe_out_fifo.sv
// First-word-fall-through buffer absorbing a non-stallable pipeline's output words.
// Optional feature macro: PIPE_OUT_FIFO_DROP_CNT_EN adds a saturating 8-bit drop counter port.
module pipe_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_out_fifo_if.slave           bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef PIPE_OUT_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("pipe_out_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop;
  logic             push;
  logic             drop;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign bus.out_valid = !empty;
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

  assign pop  = bus.out_valid && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  // Storage needs no reset; reads are gated by count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PIPE_OUT_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Scoreboard bench for pipe_out_fifo: queue-level reference model plus a decoupled output monitor.
module tb_pipe_out_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
`ifdef PIPE_OUT_FIFO_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  pipe_out_fifo_if #(.WIDTH(WIDTH)) bus ();

  pipe_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef PIPE_OUT_FIFO_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  bit         started = 0;
  logic [7:0] mq[$];     // reference FIFO contents
  logic [7:0] exp_q[$];  // scoreboard of words the consumer must see, in order
  bit         m_ovf = 0;
  int         m_dcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: checks state left by the last edge, then applies the rules for the next edge.
  always @(negedge clk) begin
    bit m_full;
    bit m_pop;
    if (started) begin
      chk("count", int'(count), mq.size());
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("out_valid", int'(bus.out_valid), int'(mq.size() != 0));
      chk("overflow", int'(overflow), int'(m_ovf));
`ifdef PIPE_OUT_FIFO_DROP_CNT_EN
      chk("drop_cnt", int'(drop_cnt), m_dcnt);
`endif
      if (mq.size() == 0) chk("out_data_idle", int'(bus.out_data), 0);
    end
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_ovf   = 0;
      m_dcnt  = 0;
      started = 1;
    end else if (started) begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && bus.out_ready;
      if (bus.in_valid && m_full && !m_pop) begin
        m_ovf = 1;
        if (m_dcnt < 255) m_dcnt++;
      end
      if (m_pop) void'(mq.pop_front());
      if (bus.in_valid && (!m_full || m_pop)) begin
        mq.push_back(bus.in_data);
        exp_q.push_back(bus.in_data);
      end
    end
  end

  // Monitor: every accepted head word must match the oldest expected word.
  always @(negedge clk) begin
    if (started && !rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", int'(bus.out_data), -1);
      end else begin
        chk("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic rs);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    rst           = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // single word, held, then consumed
    step(1, 8'hA5, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // streaming with consumer always ready
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 1, 0);
    step(0, 8'h00, 1, 0);

    // fill and overflow
    for (int i = 0; i < 6; i++) step(1, 8'(8'h10 + i), 0, 0);
    // full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 6; i++) step(1, 8'(8'h20 + i), 1, 0);
    // drop to three entries, then reset with a word presented
    step(0, 8'h00, 1, 0);
    step(1, 8'h77, 1, 1);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // ready while empty
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
    step(1, 8'h3C, 1, 0);
    step(0, 8'h00, 1, 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 199) == 0));
    end
    // sustained overflow to exercise long drop runs
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), ($urandom_range(0, 9) == 0), 0);

    budget = 0;
    while (count != '0 && budget < 40) begin
      step(0, 8'h00, 1, 0);
      budget++;
    end
    step(0, 8'h00, 0, 0);
    chk("drain_count", int'(count), 0);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
